// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the two-client SRAM arbiter: state and client encodings,
// bus widths and the latched operation type.
package sram_arbiter_pkg;

  localparam int LEN_ADDRESS  = 32;
  localparam int LEN_REGISTER = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int LEN_ARB_STATE = 2;
  localparam logic [LEN_ARB_STATE-1:0] STATE_ARB_IDLE  = 2'd0;
  localparam logic [LEN_ARB_STATE-1:0] STATE_ARB_ISSUE = 2'd1;
  localparam logic [LEN_ARB_STATE-1:0] STATE_ARB_WAIT  = 2'd2;

  localparam logic ARB_CLIENT0 = 1'b0;
  localparam logic ARB_CLIENT1 = 1'b1;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } arb_op_e;

  function automatic logic arb_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/sram_arb_rr_picker.sv
// Combinational two-way round-robin select: a sole requester wins, a tie goes
// to the client that was not granted last.
module sram_arb_rr_picker
  import sram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = (last_grant == ARB_CLIENT0) ? ARB_CLIENT1 : ARB_CLIENT0;
    end else if (req1) begin
      grant = ARB_CLIENT1;
    end else begin
      grant = ARB_CLIENT0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single SRAM controller port between two clients. Optional watchdog
// abort of stuck accesses is enabled with the SRAM_ARB_TIMEOUT_EN macro.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = LEN_ADDRESS,
  parameter int DATA_W         = LEN_REGISTER,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_done,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  logic [LEN_ARB_STATE-1:0] state;
  logic                     owner;
  logic                     last_grant;
  arb_op_e                  lat_op;
  logic [ADDR_W-1:0]        lat_addr;
  logic [DATA_W-1:0]        lat_wdata;

  logic              pick_valid;
  logic              pick_grant;
  logic              win_rd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              complete;
  logic              abort;

  sram_arb_rr_picker u_picker (
    .req0       (arb_req(c0_read, c0_write)),
    .req1       (arb_req(c1_read, c1_write)),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_comb begin
    win_rd    = (pick_grant == ARB_CLIENT1) ? c1_read  : c0_read;
    win_addr  = (pick_grant == ARB_CLIENT1) ? c1_addr  : c0_addr;
    win_wdata = (pick_grant == ARB_CLIENT1) ? c1_wdata : c0_wdata;
  end

  // The command is driven only outside IDLE, so reset drops it immediately.
  assign mem_read    = (state != STATE_ARB_IDLE) && (lat_op == OP_READ);
  assign mem_write   = (state != STATE_ARB_IDLE) && (lat_op == OP_WRITE);
  assign mem_address = lat_addr;
  assign mem_wdata   = lat_wdata;

  // mem_ready only counts in WAIT; the controller's ISSUE-cycle value is ignored.
  assign complete = (state == STATE_ARB_WAIT) && mem_ready;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;

  assign abort = (state == STATE_ARB_WAIT) && !mem_ready &&
                 (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
      err <= DISABLE;
    end else begin
      err <= abort;
      if (state == STATE_ARB_ISSUE) begin
        tmr <= '0;
      end else if (state == STATE_ARB_WAIT && !mem_ready) begin
        tmr <= tmr + 1'b1;
      end
    end
  end
`else
  assign abort = DISABLE;
  assign err   = DISABLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STATE_ARB_IDLE;
      owner      <= ARB_CLIENT0;
      last_grant <= ARB_CLIENT1;
      lat_op     <= OP_WRITE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      c0_rdata   <= '0;
      c1_rdata   <= '0;
      c0_done    <= DISABLE;
      c1_done    <= DISABLE;
    end else begin
      c0_done <= DISABLE;
      c1_done <= DISABLE;
      case (state)
        STATE_ARB_IDLE: begin
          if (pick_valid) begin
            owner     <= pick_grant;
            lat_op    <= win_rd ? OP_READ : OP_WRITE;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            state     <= STATE_ARB_ISSUE;
          end
        end
        STATE_ARB_ISSUE: state <= STATE_ARB_WAIT;
        STATE_ARB_WAIT: begin
          if (complete || abort) begin
            if (complete && lat_op == OP_READ) begin
              if (owner == ARB_CLIENT1) c1_rdata <= mem_rdata;
              else                      c0_rdata <= mem_rdata;
            end
            if (owner == ARB_CLIENT1) c1_done <= ENABLE;
            else                      c0_done <= ENABLE;
            last_grant <= owner;
            state      <= STATE_ARB_IDLE;
          end
        end
        default: state <= STATE_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter against a transaction-level
// model of the arbitration and completion rules.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c0_read = 1'b0, c0_write = 1'b0, c1_read = 1'b0, c1_write = 1'b0;
  logic [ADDR_W-1:0] c0_addr = '0, c1_addr = '0;
  logic [DATA_W-1:0] c0_wdata = '0, c1_wdata = '0;
  logic [DATA_W-1:0] c0_rdata, c1_rdata;
  logic c0_done, c1_done, mem_read, mem_write, err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_ready = 1'b0;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_done(c0_done),
    .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_done(c1_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit              m_busy = 0;
  int              m_owner = 0;
  bit              m_rd = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int              m_age = 0;
  int              m_last = 1;
  int              m_w = 0;
  logic [DATA_W-1:0] m_rdata0 = '0, m_rdata1 = '0;
  bit              m_done0 = 0, m_done1 = 0, m_err = 0;
  bit              r0, r1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_owner = 0; m_rd = 0; m_addr = '0; m_wdata = '0; m_age = 0;
      m_last = 1; m_rdata0 = '0; m_rdata1 = '0; m_done0 = 0; m_done1 = 0; m_err = 0;
    end else begin
      m_done0 = 0; m_done1 = 0; m_err = 0;
      r0 = c0_read | c0_write;
      r1 = c1_read | c1_write;
      if (!m_busy) begin
        if (r0 || r1) begin
          if (r0 && r1) m_w = (m_last == 0) ? 1 : 0;
          else          m_w = r1 ? 1 : 0;
          m_owner = m_w;
          m_rd    = (m_w == 1) ? c1_read  : c0_read;
          m_addr  = (m_w == 1) ? c1_addr  : c0_addr;
          m_wdata = (m_w == 1) ? c1_wdata : c0_wdata;
          m_busy  = 1;
          m_age   = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (mem_ready) begin
        if (m_rd) begin
          if (m_owner == 1) m_rdata1 = mem_rdata;
          else              m_rdata0 = mem_rdata;
        end
        if (m_owner == 1) m_done1 = 1; else m_done0 = 1;
        m_last = m_owner;
        m_busy = 0;
      end else begin
        m_age++;
`ifdef SRAM_ARB_TIMEOUT_EN
        if (m_age == TMO + 1) begin
          if (m_owner == 1) m_done1 = 1; else m_done0 = 1;
          m_err  = 1;
          m_last = m_owner;
          m_busy = 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    check("mem_read",    mem_read,    m_busy && m_rd);
    check("mem_write",   mem_write,   m_busy && !m_rd);
    check("mem_address", mem_address, m_addr);
    check("mem_wdata",   mem_wdata,   m_wdata);
    check("c0_done",     c0_done,     m_done0);
    check("c1_done",     c1_done,     m_done1);
    check("c0_rdata",    c0_rdata,    m_rdata0);
    check("c1_rdata",    c1_rdata,    m_rdata1);
    check("err",         err,         m_err);
  end

  // ---------------- activity counters ----------------
  int  issue_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  bit  prev_cmd = 0;
  always @(negedge clk) begin
    if ((mem_read | mem_write) && !prev_cmd) issue_cnt++;
    prev_cmd = mem_read | mem_write;
    if (c0_done) done0_cnt++;
    if (c1_done) done1_cnt++;
  end

  // ---------------- SRAM controller model ----------------
  int   cnt = 0;
  int   lat_cur = 7;
  int   ctl_lat = 7;
  bit   ctl_rand = 0;
  bit   ctl_never = 0;
  logic [DATA_W-1:0] ctl_data = 32'h1234_5678;

  always @(posedge clk) begin
    #1;
    if (mem_read | mem_write) cnt++; else cnt = 0;
    if (cnt == 1) lat_cur = ctl_rand ? int'($urandom_range(1, 6)) : ctl_lat;
    if (!ctl_never && cnt == lat_cur + 1) begin
      mem_ready = 1'b1;
      mem_rdata = ctl_rand ? DATA_W'($urandom) : ctl_data;
    end else begin
      mem_ready = (cnt <= 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      mem_rdata = DATA_W'($urandom);
    end
  end

  // ---------------- random clients ----------------
  bit drive_on = 0, start_on = 0;
  always @(posedge clk) begin
    #1;
    if (drive_on) begin
      if (c0_done) begin
        if ($urandom_range(0, 7) != 0) begin c0_read = 0; c0_write = 0; end
      end else if (!(c0_read | c0_write)) begin
        if (start_on && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0, 3: c0_read = 1;
            1: c0_write = 1;
            default: begin c0_read = 1; c0_write = 1; end
          endcase
          c0_addr = ADDR_W'($urandom); c0_wdata = DATA_W'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        c0_addr = ADDR_W'($urandom); c0_wdata = DATA_W'($urandom);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (drive_on) begin
      if (c1_done) begin
        if ($urandom_range(0, 7) != 0) begin c1_read = 0; c1_write = 0; end
      end else if (!(c1_read | c1_write)) begin
        if (start_on && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0, 3: c1_read = 1;
            1: c1_write = 1;
            default: begin c1_read = 1; c1_write = 1; end
          endcase
          c1_addr = ADDR_W'($urandom); c1_wdata = DATA_W'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        c1_addr = ADDR_W'($urandom); c1_wdata = DATA_W'($urandom);
      end
    end
  end

  // Waits for a done pulse of one client; returns edges elapsed, or limit+1.
  task automatic wait_done(input int which, input int limit, output int n);
    bit got;
    got = 0;
    n = 0;
    while (!got && n <= limit) begin
      @(posedge clk);
      n++;
      #1;
      if ((which == 0 && c0_done) || (which == 1 && c1_done)) got = 1;
    end
    if (!got) n = limit + 1;
  endtask

  int n, i0, d0, d1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_read",  mem_read,    0);
    check("rst_mem_write", mem_write,   0);
    check("rst_addr",      mem_address, 0);
    check("rst_c0_rdata",  c0_rdata,    0);
    check("rst_c1_done",   c1_done,     0);
    @(negedge clk);
    rst = 1;

    // simultaneous requests straight after reset: client 0 first
    @(posedge clk); #1;
    c0_write = 1; c0_addr = 32'h10; c0_wdata = 32'hAAAA_0001;
    c1_read = 1;  c1_addr = 32'h20;
    @(posedge clk); #1;
    check("dual_first_write", mem_write, 1);
    check("dual_first_addr",  mem_address, 32'h10);
    check("dual_first_wdata", mem_wdata, 32'hAAAA_0001);
    wait_done(0, 30, n);
    check("dual_c0_latency", n, 8);
    c0_write = 0;
    check("dual_gap_idle", mem_read | mem_write, 0);
    @(posedge clk); #1;
    check("dual_second_read", mem_read, 1);
    check("dual_second_addr", mem_address, 32'h20);
    wait_done(1, 30, n);
    check("dual_c1_rdata", c1_rdata, 32'h1234_5678);
    c1_read = 0;
    @(posedge clk); #1;
    c0_read = 1; c0_addr = 32'h30; c1_write = 1; c1_addr = 32'h50;
    @(posedge clk); #1;
    check("alt_winner_addr", mem_address, 32'h30);
    wait_done(0, 30, n);
    c0_read = 0;
    wait_done(1, 30, n);
    check("alt_c1_served", n <= 30, 1);
    c1_write = 0;
    repeat (2) @(posedge clk); #1;

    // single read, 9 edges request-to-done
    ctl_data = 32'h1234_5678;
    d1 = done1_cnt;
    c0_read = 1; c0_addr = 32'h0000_0400;
    wait_done(0, 40, n);
    c0_read = 0;
    check("single_latency", n, 9);
    check("single_rdata", c0_rdata, 32'h1234_5678);
    check("single_addr", mem_address, 32'h400);
    check("single_no_c1", done1_cnt - d1, 0);
    repeat (2) @(posedge clk); #1;

    // hold request one cycle past done: served twice
    i0 = issue_cnt; d1 = done1_cnt;
    c1_read = 1; c1_addr = 32'h60;
    wait_done(1, 40, n);
    @(posedge clk); #1;
    c1_read = 0;
    wait_done(1, 40, n);
    repeat (5) @(posedge clk); #1;
    check("hold_issues", issue_cnt - i0, 2);
    check("hold_dones", done1_cnt - d1, 2);

    // address change mid-access is ignored
    ctl_data = 32'h0BAD_F00D;
    c0_read = 1; c0_addr = 32'h40;
    repeat (4) @(posedge clk); #1;
    c0_addr = 32'h80;
    @(posedge clk); #1;
    check("midchg_addr", mem_address, 32'h40);
    wait_done(0, 40, n);
    c0_read = 0;
    check("midchg_addr_done", mem_address, 32'h40);
    check("midchg_rdata", c0_rdata, 32'h0BAD_F00D);

`ifdef SRAM_ARB_TIMEOUT_EN
    ctl_never = 1;
    @(posedge clk); #1;
    c0_read = 1; c0_addr = 32'h90;
    wait_done(0, 40, n);
    c0_read = 0;
    check("tmo_latency", n, 17);
    check("tmo_err", err, 1);
    check("tmo_rdata_kept", c0_rdata, 32'h0BAD_F00D);
    ctl_never = 0;
    c1_read = 1; c1_addr = 32'hA0;
    @(posedge clk); #1;
    check("tmo_next_grant", mem_read, 1);
    check("tmo_next_addr", mem_address, 32'hA0);
    wait_done(1, 40, n);
    c1_read = 0;
`endif

    // asynchronous reset while waiting
    @(posedge clk); #1;
    c0_read = 1; c0_addr = 32'h44;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_busy", mem_read, 1);
    rst = 0;
    #1;
    check("arst_mem_read", mem_read, 0);
    check("arst_mem_write", mem_write, 0);
    check("arst_c0_done", c0_done, 0);
    check("arst_c1_done", c1_done, 0);
    c0_read = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    c1_write = 1; c1_addr = 32'h70; c1_wdata = 32'h5555_AAAA;
    wait_done(1, 40, n);
    c1_write = 0;
    check("post_rst_latency", n, 9);
    check("post_rst_c0_rdata", c0_rdata, 0);

    // randomized traffic
    ctl_rand = 1;
    drive_on = 1; start_on = 1;
    repeat (3000) @(posedge clk);
    start_on = 0;
    repeat (80) @(posedge clk);
    #1;
    drive_on = 0;
    c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
    repeat (20) @(posedge clk);
    check("random_traffic_seen", issue_cnt > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
